// File: rtl/jtframe_ram_arb.sv
// rtl/jtframe_ram_arb.sv - four-slot round-robin arbiter in front of one SDRAM request port
// Optional watchdog on ACK/RDY: define JTFRAME_ARB_TIMEOUT_EN
module jtframe_ram_arb #(
  parameter int SDRAMW = 22,
  parameter int DW     = 16,
  parameter int TOUT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            slot_req,
  input  logic [3:0]            slot_rnw,
  input  logic [4*SDRAMW-1:0]   slot_addr,
  input  logic [4*DW-1:0]       slot_wrdata,
  output logic [3:0]            slot_we,
  output logic [3:0]            slot_din_ok,
  output logic [31:0]           slot_din,
  output logic                  sdram_req,
  output logic                  sdram_rnw,
  output logic [SDRAMW-1:0]     sdram_addr,
  output logic [DW-1:0]         sdram_wrdata,
  input  logic                  sdram_ack,
  input  logic                  sdram_rdy,
  input  logic [31:0]           sdram_dout
);

  typedef enum logic [1:0] {IDLE, ACK, RDY, GAP} state_t;

  state_t              state_q;
  logic [1:0]          ptr_q;
  logic [3:0]          we_q;
  logic [3:0]          din_ok_q;
  logic [31:0]         din_q;
  logic                req_q;
  logic                rnw_q;
  logic [SDRAMW-1:0]   addr_q;
  logic [DW-1:0]       wrdata_q;

  logic                hit_d;
  logic [1:0]          pick_d;
  logic [1:0]          cand;
  logic                tout_hit;

`ifdef JTFRAME_ARB_TIMEOUT_EN
  // The counter reaches all-ones on the edge that sees this value
  localparam logic [TOUT-1:0] TOUT_LAST = {TOUT{1'b1}} - 1'b1;
  logic [TOUT-1:0]     tout_q;
  assign tout_hit = (tout_q == TOUT_LAST);
`else
  // No watchdog: TOUT has no role, and this is constant 0 for any legal width
  assign tout_hit = (TOUT < 1);
`endif

  // Search from the slot after the last one served; the nearest requester wins
  always_comb begin
    hit_d  = 1'b0;
    pick_d = ptr_q;
    cand   = ptr_q;
    for (int i = 4; i >= 1; i--) begin
      cand = ptr_q + 2'(i);
      if (slot_req[cand]) begin
        hit_d  = 1'b1;
        pick_d = cand;
      end
    end
  end

  // Arbiter FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      we_q     <= 4'd0;
      din_ok_q <= 4'd0;
      din_q    <= 32'd0;
      req_q    <= 1'b0;
      rnw_q    <= 1'b1;
      addr_q   <= '0;
      wrdata_q <= '0;
`ifdef JTFRAME_ARB_TIMEOUT_EN
      tout_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_d) begin
            ptr_q    <= pick_d;
            addr_q   <= slot_addr[int'(pick_d)*SDRAMW +: SDRAMW];
            wrdata_q <= slot_wrdata[int'(pick_d)*DW +: DW];
            rnw_q    <= slot_rnw[pick_d];
            req_q    <= 1'b1;
            we_q     <= 4'b0001 << pick_d;
            state_q  <= ACK;
`ifdef JTFRAME_ARB_TIMEOUT_EN
            tout_q   <= '0;
`endif
          end
        end
        ACK: begin
          if (sdram_ack && sdram_rdy) begin
            // Controller finished in the same cycle it accepted: complete now
            req_q    <= 1'b0;
            if (rnw_q) din_q <= sdram_dout;
            din_ok_q <= we_q;
            state_q  <= GAP;
          end else if (sdram_ack) begin
            req_q    <= 1'b0;
            state_q  <= RDY;
          end else if (tout_hit) begin
            req_q    <= 1'b0;
            din_ok_q <= we_q;
            state_q  <= GAP;
          end
`ifdef JTFRAME_ARB_TIMEOUT_EN
          tout_q <= tout_q + 1'b1;
`endif
        end
        RDY: begin
          if (sdram_rdy) begin
            if (rnw_q) din_q <= sdram_dout;
            din_ok_q <= we_q;
            state_q  <= GAP;
          end else if (tout_hit) begin
            din_ok_q <= we_q;
            state_q  <= GAP;
          end
`ifdef JTFRAME_ARB_TIMEOUT_EN
          tout_q <= tout_q + 1'b1;
`endif
        end
        GAP: begin
          // One dead cycle so a requester still holding req is not regranted
          we_q     <= 4'd0;
          din_ok_q <= 4'd0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slot_we      = we_q;
  assign slot_din_ok  = din_ok_q;
  assign slot_din     = din_q;
  assign sdram_req    = req_q;
  assign sdram_rnw    = rnw_q;
  assign sdram_addr   = addr_q;
  assign sdram_wrdata = wrdata_q;

endmodule

// File: doc/jtframe_ram_arb.md
Name: jtframe_ram_arb

Overview:
- Four-slot round-robin arbiter that sits directly downstream of the per-slot SDRAM request stages.
- Each slot presents req/rnw/address/write-data. The arbiter serialises them onto a single request port of the SDRAM controller and returns per-slot "we" (serving) and "din_ok" (data ready) strobes, plus a shared 32-bit read bus.
- A slot's request is latched at grant, so the slot may drop req as soon as it sees its "we" line high.

Parameters:
- SDRAMW, 22, SDRAM word-address width.
- DW, 16, write-data width per slot.
- TOUT, 8, watchdog counter width; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- slot_req  input  4  per-slot request level.
- slot_rnw  input  4  per-slot 1=read, 0=write.
- slot_addr  input  4*SDRAMW  slot k at bits [k*SDRAMW +: SDRAMW].
- slot_wrdata  input  4*DW  slot k at bits [k*DW +: DW].
- slot_we  output  4  one-hot; high while slot k is being served.
- slot_din_ok  output  4  one-hot, one-cycle strobe; read data valid or write done.
- slot_din  output  32  last data from the SDRAM controller, shared by all slots.
- sdram_req  output  1  request to the controller.
- sdram_rnw  output  1  direction of the current request.
- sdram_addr  output  SDRAMW  latched address.
- sdram_wrdata  output  DW  latched write data.
- sdram_ack  input  1  controller accepted the request (one-cycle pulse).
- sdram_rdy  input  1  controller finished (one-cycle pulse); read data is on sdram_dout.
- sdram_dout  input  32  read data.

Behaviour:
- Reset values: slot_we=0, slot_din_ok=0, slot_din=0, sdram_req=0, sdram_rnw=1, sdram_addr=0, sdram_wrdata=0, state=IDLE, round-robin pointer=0.
- Reset has priority over every other event, including mid-transaction; any in-flight grant is dropped silently.
- FSM states: IDLE, ACK, RDY, GAP.
- IDLE:
  - Search from slot (ptr+1) mod 4 upward; pick the first k with slot_req[k]=1.
  - On a hit, same edge: latch addr/wrdata/rnw of slot k, set sdram_req=1, slot_we[k]=1, ptr=k, go to ACK.
  - Latency from req high to slot_we high: 1 cycle.
- ACK:
  - Hold sdram_req=1 until sdram_ack.
  - On ack: sdram_req=0, go to RDY.
  - If sdram_ack and sdram_rdy arrive in the same cycle, act as RDY directly (skip to completion).
- RDY:
  - On sdram_rdy: slot_din<=sdram_dout (reads only; writes leave slot_din unchanged), slot_din_ok[k]=1 for one cycle, go to GAP.
  - slot_we[k] stays high through the cycle in which slot_din_ok[k] is high.
- GAP:
  - slot_we=0, slot_din_ok=0.
  - One cycle with no grant, so a stale req level is not regranted.
  - Then go to IDLE.
- Timing:
  - sdram_ack/sdram_rdy outside ACK/RDY are ignored.
  - Minimum turnaround per request is 4 cycles (IDLE, ACK, RDY, GAP) when ack and rdy each take one cycle.
- Fairness:
  - The slot just served has lowest priority next round.
  - With all four requesting continuously, grant order from reset is 1,2,3,0,1,...
- Request changes: slot_req falling before grant withdraws the request. Changes to a slot's addr/rnw after grant are ignored.
- At most one bit of slot_we and of slot_din_ok is ever high.

Optional Feature:
- JTFRAME_ARB_TIMEOUT_EN defined:
  - A TOUT-bit counter clears on entry to ACK and counts in ACK and RDY.
  - On reaching all-ones: drop sdram_req, pulse slot_din_ok[k] with slot_din unchanged, go to GAP.
  - The arbiter never hangs on a missing ack/rdy.
- Undefined: no counter; ACK and RDY wait indefinitely.

Test Plan:
- Single read: slot_req=4'b0100, slot 2 addr=22'h01234; ack 2 cycles later, rdy 3 cycles after ack with sdram_dout=32'hCAFE_F00D -> sdram_addr=22'h01234, sdram_rnw=1, slot_we[2] high 1 cycle after req through the din_ok cycle, slot_din=32'hCAFE_F00D, one-cycle din_ok[2].
- Write: slot 0 rnw=0, wrdata=16'hA55A -> sdram_rnw=0, sdram_wrdata=16'hA55A; on rdy, din_ok[0] pulses and slot_din unchanged.
- Round robin: all four req held high from reset, ack/rdy each one cycle -> grant order 1,2,3,0,1; exactly 4 cycles between consecutive grants.
- Same-cycle ack+rdy: assert both in the first ACK cycle -> din_ok in that cycle's next edge, then GAP, then IDLE.
- Reset mid-RDY: rst high one cycle while waiting for rdy -> next cycle all outputs at reset values; a later rdy pulse produces no din_ok.
- With JTFRAME_ARB_TIMEOUT_EN, TOUT=4, no ack -> sdram_req drops and din_ok pulses after 15 cycles in ACK; the next slot is granted afterwards.
